// File: rtl/axi_rw_arbiter.sv
// axi_rw_arbiter: shares one AXI3 master port between icache (s0) and the
// uncached data bridge (s1); read and write paths arbitrate independently.
module axi_rw_arbiter #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [2*ID_W-1:0]        s_arid,
  input  logic [2*ADDR_W-1:0]      s_araddr,
  input  logic [7:0]               s_arlen,
  input  logic [5:0]               s_arsize,
  input  logic [3:0]               s_arburst,
  input  logic [1:0]               s_arvalid,
  output logic [1:0]               s_arready,
  output logic [ID_W-1:0]          s_rid,
  output logic [DATA_W-1:0]        s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rlast,
  output logic [1:0]               s_rvalid,
  input  logic [1:0]               s_rready,
  input  logic [2*ID_W-1:0]        s_awid,
  input  logic [2*ADDR_W-1:0]      s_awaddr,
  input  logic [7:0]               s_awlen,
  input  logic [5:0]               s_awsize,
  input  logic [3:0]               s_awburst,
  input  logic [1:0]               s_awvalid,
  output logic [1:0]               s_awready,
  input  logic [2*ID_W-1:0]        s_wid,
  input  logic [2*DATA_W-1:0]      s_wdata,
  input  logic [2*(DATA_W/8)-1:0]  s_wstrb,
  input  logic [1:0]               s_wlast,
  input  logic [1:0]               s_wvalid,
  output logic [1:0]               s_wready,
  output logic [ID_W-1:0]          s_bid,
  output logic [1:0]               s_bresp,
  output logic [1:0]               s_bvalid,
  input  logic [1:0]               s_bready,
  output logic [ID_W-1:0]          m_arid,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [3:0]               m_arlen,
  output logic [2:0]               m_arsize,
  output logic [1:0]               m_arburst,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [ID_W-1:0]          m_rid,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  output logic [ID_W-1:0]          m_awid,
  output logic [ADDR_W-1:0]        m_awaddr,
  output logic [3:0]               m_awlen,
  output logic [2:0]               m_awsize,
  output logic [1:0]               m_awburst,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [ID_W-1:0]          m_wid,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W/8-1:0]      m_wstrb,
  output logic                     m_wlast,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  logic [ID_W-1:0]          m_bid,
  input  logic [1:0]               m_bresp,
  input  logic                     m_bvalid,
  output logic                     m_bready
);

  localparam int SW = DATA_W / 8;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ACT  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [1:0] r_rd_state;
  logic [1:0] r_wr_state;
  logic       r_rgnt;
  logic       r_wgnt;
  logic       r_rd_last;
  logic       r_wr_last;
  logic       r_aw_done;
  logic       r_w_done;

  logic       w_rwin;
  logic       w_wwin;
  logic       w_s_wvalid;
  logic       w_aw_set;
  logic       w_w_set;

  // Tie goes to the slave not served last, unless data has fixed priority
  function automatic logic pick(input logic [1:0] req, input logic last);
    logic win;
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = (FIXED_PRI != 0) ? 1'b1 : ~last;
    endcase
    return win;
  endfunction

  assign w_rwin = pick(s_arvalid, r_rd_last);
  assign w_wwin = pick(s_awvalid, r_wr_last);

  assign m_arid    = r_rgnt ? s_arid[2*ID_W-1:ID_W]       : s_arid[ID_W-1:0];
  assign m_araddr  = r_rgnt ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
  assign m_arlen   = r_rgnt ? s_arlen[7:4]   : s_arlen[3:0];
  assign m_arsize  = r_rgnt ? s_arsize[5:3]  : s_arsize[2:0];
  assign m_arburst = r_rgnt ? s_arburst[3:2] : s_arburst[1:0];

  assign s_rid   = m_rid;
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

  assign m_awid    = r_wgnt ? s_awid[2*ID_W-1:ID_W]       : s_awid[ID_W-1:0];
  assign m_awaddr  = r_wgnt ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
  assign m_awlen   = r_wgnt ? s_awlen[7:4]   : s_awlen[3:0];
  assign m_awsize  = r_wgnt ? s_awsize[5:3]  : s_awsize[2:0];
  assign m_awburst = r_wgnt ? s_awburst[3:2] : s_awburst[1:0];

  assign m_wid   = r_wgnt ? s_wid[2*ID_W-1:ID_W]       : s_wid[ID_W-1:0];
  assign m_wdata = r_wgnt ? s_wdata[2*DATA_W-1:DATA_W] : s_wdata[DATA_W-1:0];
  assign m_wstrb = r_wgnt ? s_wstrb[2*SW-1:SW]         : s_wstrb[SW-1:0];
  assign m_wlast = r_wgnt ? s_wlast[1] : s_wlast[0];

  assign w_s_wvalid = r_wgnt ? s_wvalid[1] : s_wvalid[0];

  assign s_bid   = m_bid;
  assign s_bresp = m_bresp;

  always_comb begin
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = 2'b00;
    s_rvalid  = 2'b00;
    unique case (r_rd_state)
      R_ADDR: begin
        m_arvalid         = 1'b1;
        s_arready[r_rgnt] = m_arready;
      end
      R_DATA: begin
        s_rvalid[r_rgnt] = m_rvalid;
        m_rready         = s_rready[r_rgnt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_state <= R_IDLE;
      r_rgnt     <= 1'b0;
      r_rd_last  <= 1'b1;
    end else begin
      unique case (r_rd_state)
        R_IDLE: if (|s_arvalid) begin
          r_rgnt     <= w_rwin;
          r_rd_state <= R_ADDR;
        end
        R_ADDR: if (m_arready) r_rd_state <= R_DATA;
        R_DATA: if (m_rvalid && m_rready && m_rlast) begin
          r_rd_state <= R_IDLE;
          r_rd_last  <= r_rgnt;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_awready = 2'b00;
    s_wready  = 2'b00;
    s_bvalid  = 2'b00;
    unique case (r_wr_state)
      W_ACT: begin
        m_awvalid         = ~r_aw_done;
        m_wvalid          = w_s_wvalid & ~r_w_done;
        s_awready[r_wgnt] = m_awready & ~r_aw_done;
        s_wready[r_wgnt]  = m_wready & ~r_w_done;
      end
      W_RESP: begin
        s_bvalid[r_wgnt] = m_bvalid;
        m_bready         = s_bready[r_wgnt];
      end
      default: ;
    endcase
  end

  // AW and the last W beat may finish in either order or together
  assign w_aw_set = r_aw_done | (m_awvalid & m_awready);
  assign w_w_set  = r_w_done | (m_wvalid & m_wready & m_wlast);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state <= W_IDLE;
      r_wgnt     <= 1'b0;
      r_wr_last  <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      unique case (r_wr_state)
        W_IDLE: if (|s_awvalid) begin
          r_wgnt     <= w_wwin;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
          r_wr_state <= W_ACT;
        end
        W_ACT: begin
          r_aw_done <= w_aw_set;
          r_w_done  <= w_w_set;
          if (w_aw_set && w_w_set) r_wr_state <= W_RESP;
        end
        W_RESP: if (m_bvalid && m_bready) begin
          r_wr_state <= W_IDLE;
          r_wr_last  <= r_wgnt;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

endmodule
